alu_mp_seq: RTL and testbench
=============================

Name: alu_mp_seq

Overview:
Multi-precision add/subtract sequencer that sits directly upstream of the combinational alu. It accepts a WORDS*N-bit operand pair and feeds the alu one N-bit limb per cycle, least significant limb first, chaining cout into cin. It assembles the wide result plus carry, overflow, sign and zero flags and reports completion with a one-cycle done pulse.

Parameters:
N, 8, alu datapath width (limb width); must equal the attached alu's width.
WORDS, 4, number of limbs; minimum 1; total operand width W = N*WORDS.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request a new operation; sampled only in IDLE.
sub  in  1  0 = add, 1 = subtract; sampled with start.
opa  in  W  operand A; sampled with start.
opb  in  W  operand B; sampled with start.
busy  out  1  high while an operation is in progress (RUN and DONE).
done  out  1  one-cycle completion pulse.
result  out  W  wide result; holds its value between operations.
carry  out  1  final limb cout (carry for add, borrow for sub).
overflow  out  1  signed overflow of the full W-bit operation.
sign  out  1  result[W-1].
zero  out  1  1 when the full W-bit result is 0.
alu_a  out  N  current limb of A to the alu.
alu_b  out  N  current limb of B to the alu.
alu_op  out  7  `ALU_ADD or `ALU_SUB, from the alu opcode macros.
alu_cin  out  1  carry/borrow into the current limb.
alu_out  in  N  alu result.
alu_cout  in  1  alu carry/borrow out.
alu_overflow  in  1  alu signed overflow.
alu_sign  in  1  alu sign.
alu_zero  in  1  alu zero.

Behaviour:
- ALU contract: ADD gives out = a+b+cin with cout = carry. SUB gives out = a-b-cin with cout = borrow. The alu is purely combinational, so each limb result is captured in the same cycle it is driven.
- Reset: state IDLE. busy, done, carry, overflow, sign and zero are 0. result is 0. The internal limb index, carry register, operand and shadow registers are cleared. alu_a and alu_b are 0, alu_op is `ALU_ADD and alu_cin is 0.
- FSM has three states: IDLE, RUN and DONE.
- IDLE with start=1:
  - latch opa, opb and sub;
  - set index to 0, carry register to 0 and zero accumulator to 1;
  - go to RUN.
- IDLE with start=0: stay in IDLE. alu_a and alu_b are 0 and alu_op is `ALU_ADD.
- RUN, each cycle:
  - drive alu_a and alu_b with limb[index] of the latched operands, alu_cin with the carry register, and alu_op according to the latched sub;
  - at the clock edge, write alu_out into shadow limb[index], load the carry register with alu_cout, and AND the zero accumulator with alu_zero.
- RUN at index = WORDS-1: additionally capture alu_overflow and alu_sign, then go to DONE. Otherwise increment index.
- First limb cin is always 0, for both add and subtract.
- DONE, for one cycle:
  - done = 1 and busy = 1;
  - result, carry, overflow, sign and zero are already updated from the shadow and captured values;
  - next state is IDLE unconditionally.
- Output timing: result and the flags change only at the clock edge that enters DONE. They hold otherwise, including while the next operation runs.
- Latency: with start sampled at edge t, done is high in the cycle following edge t+WORDS. That is WORDS+1 cycles from acceptance to done; the next start can be accepted at edge t+WORDS+2.
- busy goes high in the cycle after start is accepted and stays high through the DONE cycle.
- start while busy=1 is ignored and never queued. Changing opa, opb or sub during RUN has no effect.
- WORDS=1: one RUN cycle; behaviour is identical to a single alu operation with cin=0.
- Reset mid-operation: immediate return to the reset state. No done pulse, and result and flags are cleared.
- overflow and sign come from the most significant limb only. zero covers all limbs.

Test Plan:
1. N=8, WORDS=4, add 0x000000FF + 0x00000001 -> result 0x00000100, carry=0, zero=0, overflow=0, sign=0. done is high exactly 5 cycles after the start edge, busy is high for those 5 cycles, and done is a single pulse.
2. Add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry=1, zero=1, overflow=0. Add 0x7FFFFFFF + 0x00000001 -> 0x80000000, overflow=1, sign=1, carry=0.
3. Sub 0x00000100 - 0x00000001 -> 0x000000FF, carry=0. Sub 0x00000001 - 0x00000002 -> 0xFFFFFFFF, carry=1, sign=1, overflow=0. Sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, overflow=1. Sub 0x12345678 - 0x12345678 -> 0, zero=1.
4. Per-limb driving: during add 0x01020304 + 0x10203040, alu_a/alu_b read 04/40, 03/30, 02/20, 01/10 on consecutive RUN cycles, and alu_cin is 0 on the first cycle.
5. Pulse start with new operands during RUN -> ignored, and the first result is unchanged. Assert rst_n=0 in the 2nd RUN cycle -> all outputs 0 immediately and no done pulse. After release, a new start completes correctly.
6. WORDS=1: add 0xFF + 0x01 -> result 0x00, carry=1, zero=1, with done 2 cycles after the start edge.

Source files
------------

// File: rtl/alu_mp_seq.sv
// Multi-precision add/subtract sequencer: streams WORDS limbs (LS first) through an external
// N-bit combinational alu, chaining carry/borrow, and assembles the wide result plus flags.
`ifndef ALU_ADD
`define ALU_ADD 7'h01
`endif
`ifndef ALU_SUB
`define ALU_SUB 7'h02
`endif

module alu_mp_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [N*WORDS-1:0]   opa,
  input  logic [N*WORDS-1:0]   opb,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   result,
  output logic                 carry,
  output logic                 overflow,
  output logic                 sign,
  output logic                 zero,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic [6:0]           alu_op,
  output logic                 alu_cin,
  input  logic [N-1:0]         alu_out,
  input  logic                 alu_cout,
  input  logic                 alu_overflow,
  input  logic                 alu_sign,
  input  logic                 alu_zero
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d;
  logic            zacc_q, zacc_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d, ovf_q, ovf_d, sign_q, sign_d, zero_q, zero_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cy_d     = cy_q;
    zacc_d   = zacc_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    busy     = 1'b0;
    done     = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = `ALU_ADD;
    alu_cin  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = opa;
          b_d     = opb;
          sub_d   = sub;
          idx_d   = '0;
          cy_d    = 1'b0;
          zacc_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        // Latched operands shift down one limb per cycle, so the current limb is always at bit 0.
        alu_a   = a_q[N-1:0];
        alu_b   = b_q[N-1:0];
        alu_cin = cy_q;
        alu_op  = sub_q ? `ALU_SUB : `ALU_ADD;
        a_d     = a_q >> N;
        b_d     = b_q >> N;
        // Limbs enter at the top and slide down; after WORDS cycles limb i sits at position i.
        shadow_d = (shadow_q >> N) | (W'(alu_out) << (W - N));
        cy_d     = alu_cout;
        zacc_d   = zacc_q & alu_zero;
        if (idx_q == IW'(WORDS - 1)) begin
          result_d = shadow_d;
          carry_d  = alu_cout;
          ovf_d    = alu_overflow;
          sign_d   = alu_sign;
          zero_d   = zacc_d;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cy_q     <= 1'b0;
      zacc_q   <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cy_q     <= cy_d;
      zacc_q   <= zacc_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign sign     = sign_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu_mp_seq.sv
// Bench for alu_mp_seq: a 4-limb and a 1-limb instance, each driven by a behavioural 8-bit alu.
`ifndef ALU_ADD
`define ALU_ADD 7'h01
`endif
`ifndef ALU_SUB
`define ALU_SUB 7'h02
`endif

module tb_alu_mp_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start_s [2];
  logic        sub_s   [2];
  logic [31:0] opa_s   [2];
  logic [31:0] opb_s   [2];

  logic        o_busy [2], o_done [2], o_c [2], o_o [2], o_s [2], o_z [2], o_cin [2];
  logic [7:0]  o_a [2], o_b [2];
  logic [6:0]  o_op [2];
  logic [31:0] o_res [2];
  logic [31:0] res0;
  logic [7:0]  res1;
  logic [9:0]  alu_r [2];

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic [6:0] op);
    logic [8:0] s;
    logic       ov;
    if (op == `ALU_SUB) begin
      s  = {1'b0, a} - {1'b0, b} - {8'h00, cin};
      ov = (a[7] != b[7]) && (s[7] != a[7]);
    end else begin
      s  = {1'b0, a} + {1'b0, b} + {8'h00, cin};
      ov = (a[7] == b[7]) && (s[7] != a[7]);
    end
    return {ov, s};
  endfunction

  function automatic int words(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic [63:0] msk(input int w);
    return (64'h1 << w) - 64'h1;
  endfunction

  assign alu_r[0] = alu_f(o_a[0], o_b[0], o_cin[0], o_op[0]);
  assign alu_r[1] = alu_f(o_a[1], o_b[1], o_cin[1], o_op[1]);
  assign o_res[0] = res0;
  assign o_res[1] = {24'h0, res1};

  alu_mp_seq #(.N(8), .WORDS(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .sub(sub_s[0]),
    .opa(opa_s[0]), .opb(opb_s[0]), .busy(o_busy[0]), .done(o_done[0]),
    .result(res0), .carry(o_c[0]), .overflow(o_o[0]), .sign(o_s[0]), .zero(o_z[0]),
    .alu_a(o_a[0]), .alu_b(o_b[0]), .alu_op(o_op[0]), .alu_cin(o_cin[0]),
    .alu_out(alu_r[0][7:0]), .alu_cout(alu_r[0][8]), .alu_overflow(alu_r[0][9]),
    .alu_sign(alu_r[0][7]), .alu_zero(alu_r[0][7:0] == 8'h00));

  alu_mp_seq #(.N(8), .WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .sub(sub_s[1]),
    .opa(opa_s[1][7:0]), .opb(opb_s[1][7:0]), .busy(o_busy[1]), .done(o_done[1]),
    .result(res1), .carry(o_c[1]), .overflow(o_o[1]), .sign(o_s[1]), .zero(o_z[1]),
    .alu_a(o_a[1]), .alu_b(o_b[1]), .alu_op(o_op[1]), .alu_cin(o_cin[1]),
    .alu_out(alu_r[1][7:0]), .alu_cout(alu_r[1][8]), .alu_overflow(alu_r[1][9]),
    .alu_sign(alu_r[1][7]), .alu_zero(alu_r[1][7:0] == 8'h00));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: ml counts cycles left in the operation (WORDS+1 at acceptance, 1 in the done cycle).
  int          ml [2] = '{0, 0};
  logic [31:0] pa [2], pb [2];
  logic        psub [2];
  logic [31:0] m_res [2];
  logic        m_c [2], m_o [2], m_s [2], m_z [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ml[k] = 0; pa[k] = '0; pb[k] = '0; psub[k] = 1'b0;
        m_res[k] = '0; m_c[k] = 1'b0; m_o[k] = 1'b0; m_s[k] = 1'b0; m_z[k] = 1'b0;
      end else if (ml[k] == 0) begin
        if (start_s[k]) begin
          ml[k]   = words(k) + 1;
          pa[k]   = 32'(64'(opa_s[k]) & msk(8 * words(k)));
          pb[k]   = 32'(64'(opb_s[k]) & msk(8 * words(k)));
          psub[k] = sub_s[k];
        end
      end else begin
        ml[k] = ml[k] - 1;
        if (ml[k] == 1) begin
          automatic int w = 8 * words(k);
          automatic logic [63:0] x = psub[k] ? (64'(pa[k]) - 64'(pb[k])) : (64'(pa[k]) + 64'(pb[k]));
          m_res[k] = 32'(x & msk(w));
          m_c[k]   = psub[k] ? (pa[k] < pb[k]) : x[w];
          m_s[k]   = m_res[k][w-1];
          m_o[k]   = psub[k] ? ((pa[k][w-1] != pb[k][w-1]) && (m_s[k] != pa[k][w-1]))
                             : ((pa[k][w-1] == pb[k][w-1]) && (m_s[k] != pa[k][w-1]));
          m_z[k]   = (m_res[k] == 32'h0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        automatic logic [31:0] ea = 0, eb = 0;
        automatic logic        ecin = 1'b0;
        automatic logic [6:0]  eop = `ALU_ADD;
        if (ml[k] >= 2) begin
          automatic int i = words(k) + 1 - ml[k];
          automatic logic [63:0] la = 64'(pa[k]) & msk(8 * i);
          automatic logic [63:0] lb = 64'(pb[k]) & msk(8 * i);
          ea   = (pa[k] >> (8 * i)) & 32'hFF;
          eb   = (pb[k] >> (8 * i)) & 32'hFF;
          ecin = psub[k] ? (la < lb) : (((la + lb) >> (8 * i)) != 64'h0);
          eop  = psub[k] ? `ALU_SUB : `ALU_ADD;
        end
        chk($sformatf("cyc%0d busy", k),   32'(o_busy[k]), 32'(ml[k] > 0));
        chk($sformatf("cyc%0d done", k),   32'(o_done[k]), 32'(ml[k] == 1));
        chk($sformatf("cyc%0d result", k), o_res[k], m_res[k]);
        chk($sformatf("cyc%0d flags", k),  {28'h0, o_c[k], o_o[k], o_s[k], o_z[k]},
                                           {28'h0, m_c[k], m_o[k], m_s[k], m_z[k]});
        chk($sformatf("cyc%0d alu_a", k),  32'(o_a[k]), ea);
        chk($sformatf("cyc%0d alu_b", k),  32'(o_b[k]), eb);
        chk($sformatf("cyc%0d alu_cin", k), 32'(o_cin[k]), 32'(ecin));
        chk($sformatf("cyc%0d alu_op", k), 32'(o_op[k]), 32'(eop));
      end
    end
  end

  // Drive a start; returns just after the accepting edge with start already dropped.
  task automatic launch(input int k, input logic s, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start_s[k] = 1'b1; sub_s[k] = s; opa_s[k] = a; opb_s[k] = b;
    @(posedge clk);
    #1;
    start_s[k] = 1'b0;
  endtask

  task automatic collect(input string nm, input int k, input int exp_n,
                         input logic [31:0] er, input logic ec, input logic eo,
                         input logic es, input logic ez);
    int n = 0;
    int nb = 0;
    bit got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (o_busy[k]) nb++;
      if (o_done[k]) got = 1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done within 20 cycles", nm);
    end else begin
      if (exp_n > 0) begin
        chk({nm, " latency"}, 32'(n), 32'(exp_n));
        chk({nm, " busy_cycles"}, 32'(nb), 32'(exp_n));
      end
      chk({nm, " result"}, o_res[k], er);
      chk({nm, " carry"}, 32'(o_c[k]), 32'(ec));
      chk({nm, " overflow"}, 32'(o_o[k]), 32'(eo));
      chk({nm, " sign"}, 32'(o_s[k]), 32'(es));
      chk({nm, " zero"}, 32'(o_z[k]), 32'(ez));
      @(negedge clk);
      chk({nm, " single_pulse"}, 32'(o_done[k]), 32'h0);
    end
  endtask

  initial begin
    logic [7:0] la [4];
    logic [7:0] lb [4];
    la = '{8'h04, 8'h03, 8'h02, 8'h01};
    lb = '{8'h40, 8'h30, 8'h20, 8'h10};
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0; sub_s[k] = 1'b0; opa_s[k] = '0; opb_s[k] = '0;
    end
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset busy", 32'(o_busy[0]), 32'h0);
    chk("reset result", res0, 32'h0);
    chk("reset alu_op", 32'(o_op[0]), 32'(`ALU_ADD));

    launch(0, 1'b0, 32'h000000FF, 32'h00000001);
    collect("add_ff_1", 0, 5, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0);
    launch(0, 1'b0, 32'hFFFFFFFF, 32'h00000001);
    collect("add_wrap", 0, 5, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
    launch(0, 1'b0, 32'h7FFFFFFF, 32'h00000001);
    collect("add_ovf", 0, 5, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0);
    launch(0, 1'b1, 32'h00000100, 32'h00000001);
    collect("sub_borrow_chain", 0, 5, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0);
    launch(0, 1'b1, 32'h00000001, 32'h00000002);
    collect("sub_neg", 0, 5, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    launch(0, 1'b1, 32'h80000000, 32'h00000001);
    collect("sub_ovf", 0, 5, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    launch(0, 1'b1, 32'h12345678, 32'h12345678);
    collect("sub_zero", 0, 5, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1);

    launch(0, 1'b0, 32'h01020304, 32'h10203040);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      chk($sformatf("limb%0d alu_a", i), 32'(o_a[0]), 32'(la[i]));
      chk($sformatf("limb%0d alu_b", i), 32'(o_b[0]), 32'(lb[i]));
      if (i == 0) chk("limb0 alu_cin", 32'(o_cin[0]), 32'h0);
    end
    collect("limbs", 0, 0, 32'h11223344, 1'b0, 1'b0, 1'b0, 1'b0);

    launch(0, 1'b0, 32'h00000010, 32'h00000020);
    @(posedge clk);
    #1;
    start_s[0] = 1'b1; sub_s[0] = 1'b1; opa_s[0] = 32'hAAAAAAAA; opb_s[0] = 32'h11111111;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    collect("ignore_start", 0, 0, 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    launch(0, 1'b0, 32'h11111111, 32'h22222222);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(o_busy[0]), 32'h0);
    chk("midreset done", 32'(o_done[0]), 32'h0);
    chk("midreset result", res0, 32'h0);
    chk("midreset alu_a", 32'(o_a[0]), 32'h0);
    chk("midreset flags", {28'h0, o_c[0], o_o[0], o_s[0], o_z[0]}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    launch(0, 1'b0, 32'h0000FFFF, 32'h00000001);
    collect("after_reset", 0, 5, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0);

    launch(1, 1'b0, 32'h000000FF, 32'h00000001);
    collect("w1_add", 1, 2, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
    launch(1, 1'b1, 32'h00000080, 32'h00000001);
    collect("w1_sub_ovf", 1, 2, 32'h0000007F, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
